// File: rtl/case_1_op_pkg.sv
// Shared operator definitions for the case_1 multiply / multiply-accumulate cores:
// mode encoding plus the sign-extension and saturation-detection helpers.
package case_1_op_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

    // Outcome of range-checking a sum that carries one guard bit above the result width
    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HI   = 2'd1,
        SAT_LO   = 2'd2
    } sat_kind_t;

    // Fill bit used when widening a value: its sign bit for signed data, zero otherwise
    function automatic logic ext_fill(input logic sgn, input logic msb);
        logic fill;
        if (sgn) begin
            fill = msb;
        end else begin
            fill = 1'b0;
        end
        return fill;
    endfunction

    // Classify a (width+1)-bit sum from its two top bits. Signed: the guard bit and the
    // result MSB disagree on overflow, and the guard bit gives the direction. Unsigned:
    // the guard bit alone flags an overflow above the maximum.
    function automatic sat_kind_t sat_check(input logic sgn, input logic top, input logic next);
        sat_kind_t kind;
        if (sgn) begin
            if (top != next) begin
                kind = top ? SAT_LO : SAT_HI;
            end else begin
                kind = SAT_NONE;
            end
        end else begin
            kind = top ? SAT_HI : SAT_NONE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/case_1_pipe_dly.sv
// Generic clock-enabled delay line with a valid bit, DEPTH >= 1 registers deep.
// Holds every register while ce is low; synchronous reset clears the whole line.
module case_1_pipe_dly #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             d_vld,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_vld,
    output logic [WIDTH-1:0] q_data
);

    logic [DEPTH-1:0] vld_r;
    logic [WIDTH-1:0] data_r [DEPTH];

    // Shift valid and payload one stage on every enabled edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= {WIDTH{1'b0}};
            end
        end else if (ce) begin
            vld_r[0]  <= d_vld;
            data_r[0] <= d_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i]  <= vld_r[i-1];
                data_r[i] <= data_r[i-1];
            end
        end
    end

    assign q_vld  = vld_r[DEPTH-1];
    assign q_data = data_r[DEPTH-1];

endmodule

// File: rtl/case_1_mac_pipe_ce.sv
// Pipelined multiplier / multiply-accumulate with clock enable, valid tracking,
// signed/unsigned operands and a saturating or wrapping accumulator.
// Stage 1 registers operands, the product is formed after it, middle stages are
// pure delay, and the final stage performs the accumulate and range handling.
import case_1_op_pkg::*;

module case_1_mac_pipe_ce #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 4,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 12,
    parameter int SIGNED     = 1,
    parameter int SAT        = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  mode,
    input  logic                  acc_clr,
    output logic                  out_vld,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int   PW  = din0_WIDTH + din1_WIDTH;
    localparam int   SW  = dout_WIDTH + 1;
    localparam logic SGN = (SIGNED != 0);

    localparam logic [dout_WIDTH-1:0] MAX_C = SGN ? {1'b0, {(dout_WIDTH-1){1'b1}}}
                                                  : {dout_WIDTH{1'b1}};
    localparam logic [dout_WIDTH-1:0] MIN_C = SGN ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                                  : {dout_WIDTH{1'b0}};

    // Operand side feeding the multiplier
    logic [din0_WIDTH-1:0] op_a_s;
    logic [din1_WIDTH-1:0] op_b_s;
    logic                  op_vld_s;
    logic                  op_mode_s;
    logic                  op_clr_s;

    // Multiplier
    logic [PW-1:0] a_pw_s;
    logic [PW-1:0] b_pw_s;
    logic [PW-1:0] prod_s;

    // Output-stage inputs after the delay line
    logic          os_vld_s;
    logic [PW+1:0] os_data_s;
    logic          os_mode_s;
    logic          os_clr_s;
    logic [PW-1:0] os_p_s;

    // Accumulate path
    logic [SW-1:0]         p_ext_s;
    logic [SW-1:0]         acc_ext_s;
    logic [SW-1:0]         base_s;
    logic [SW-1:0]         sum_s;
    sat_kind_t             kind_s;
    logic [dout_WIDTH-1:0] mac_res_s;
    logic                  mac_ovf_s;

    // Architectural state
    logic                  out_vld_r;
    logic [dout_WIDTH-1:0] dout_r;
    logic                  ovf_r;
    logic [dout_WIDTH-1:0] acc_r;

    generate
        if (NUM_STAGE == 1) begin : g_no_opreg
            // Single-stage build: the product is formed straight from the inputs
            assign op_a_s    = din0;
            assign op_b_s    = din1;
            assign op_vld_s  = in_vld;
            assign op_mode_s = mode;
            assign op_clr_s  = acc_clr;
        end else begin : g_opreg
            logic [din0_WIDTH-1:0] a_r;
            logic [din1_WIDTH-1:0] b_r;
            logic                  vld_r;
            logic                  mode_r;
            logic                  clr_r;

            // Stage 1: capture operands and per-transaction controls on enabled edges
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    a_r    <= {din0_WIDTH{1'b0}};
                    b_r    <= {din1_WIDTH{1'b0}};
                    vld_r  <= 1'b0;
                    mode_r <= 1'b0;
                    clr_r  <= 1'b0;
                end else if (ce) begin
                    a_r    <= din0;
                    b_r    <= din1;
                    vld_r  <= in_vld;
                    mode_r <= mode;
                    clr_r  <= acc_clr;
                end
            end

            assign op_a_s    = a_r;
            assign op_b_s    = b_r;
            assign op_vld_s  = vld_r;
            assign op_mode_s = mode_r;
            assign op_clr_s  = clr_r;
        end
    endgenerate

    // Widen both operands to the product width so a plain truncating multiply is exact
    always_comb begin
        a_pw_s = {{din1_WIDTH{ext_fill(SGN, op_a_s[din0_WIDTH-1])}}, op_a_s};
        b_pw_s = {{din0_WIDTH{ext_fill(SGN, op_b_s[din1_WIDTH-1])}}, op_b_s};
        prod_s = a_pw_s * b_pw_s;
    end

    generate
        if (NUM_STAGE >= 3) begin : g_dly
            case_1_pipe_dly #(
                .WIDTH (PW + 2),
                .DEPTH (NUM_STAGE - 2)
            ) u_dly (
                .clk    (ap_clk),
                .rst    (ap_rst),
                .ce     (ce),
                .d_vld  (op_vld_s),
                .d_data ({op_mode_s, op_clr_s, prod_s}),
                .q_vld  (os_vld_s),
                .q_data (os_data_s)
            );
        end else begin : g_no_dly
            assign os_vld_s  = op_vld_s;
            assign os_data_s = {op_mode_s, op_clr_s, prod_s};
        end
    endgenerate

    assign os_mode_s = os_data_s[PW+1];
    assign os_clr_s  = os_data_s[PW];
    assign os_p_s    = os_data_s[PW-1:0];

    // Accumulate with one guard bit, then clamp or wrap depending on SAT
    always_comb begin
        p_ext_s   = {{(SW-PW){ext_fill(SGN, os_p_s[PW-1])}}, os_p_s};
        acc_ext_s = {ext_fill(SGN, acc_r[dout_WIDTH-1]), acc_r};
        if (os_clr_s) begin
            base_s = {SW{1'b0}};
        end else begin
            base_s = acc_ext_s;
        end
        sum_s     = base_s + p_ext_s;
        kind_s    = sat_check(SGN, sum_s[SW-1], sum_s[SW-2]);
        mac_ovf_s = (kind_s != SAT_NONE);
        mac_res_s = sum_s[dout_WIDTH-1:0];
        if (SAT != 0) begin
            case (kind_s)
                SAT_HI:  mac_res_s = MAX_C;
                SAT_LO:  mac_res_s = MIN_C;
                default: mac_res_s = sum_s[dout_WIDTH-1:0];
            endcase
        end else begin
            mac_res_s = sum_s[dout_WIDTH-1:0];
        end
    end

    // Output stage: publish result, update accumulator only for MAC transactions
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            out_vld_r <= 1'b0;
            dout_r    <= {dout_WIDTH{1'b0}};
            ovf_r     <= 1'b0;
            acc_r     <= {dout_WIDTH{1'b0}};
        end else if (ce) begin
            out_vld_r <= os_vld_s;
            if (os_vld_s) begin
                if (os_mode_s == MODE_MAC) begin
                    dout_r <= mac_res_s;
                    ovf_r  <= mac_ovf_s;
                    acc_r  <= mac_res_s;
                end else begin
                    dout_r <= p_ext_s[dout_WIDTH-1:0];
                    ovf_r  <= 1'b0;
                end
            end
        end
    end

    assign out_vld = out_vld_r;
    assign dout    = dout_r;
    assign ovf     = ovf_r;

endmodule
